// File: rtl/matrix_pkg.sv
// matrix_pkg: constants shared by the matrix input parser and the matrix displayer.
// Holds the dimension limit, ASCII codes, FSM state encodings, error codes and the
// storage address helper (linear index r*5+c).
package matrix_pkg;

    localparam int MAX_DIM = 5;
    localparam int ACC_W   = 10;
    localparam logic [ACC_W-1:0] ACC_SAT = '1;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_GET_ROW      = 3'd1;
    localparam logic [2:0] ST_GET_COL      = 3'd2;
    localparam logic [2:0] ST_GET_ELEM     = 3'd3;
    localparam logic [2:0] ST_DONE         = 3'd4;
    localparam logic [2:0] ST_WAIT_RELEASE = 3'd5;
    localparam logic [2:0] ST_ERROR        = 3'd6;
    localparam logic [2:0] ST_FILL         = 3'd7;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHAR = 2'd1;
    localparam logic [1:0] ERR_DIM  = 2'd2;
    localparam logic [1:0] ERR_VAL  = 2'd3;

    // Storage is laid out with a fixed row pitch of 5 regardless of the parsed width.
    function automatic logic [4:0] lin_addr(input logic [2:0] r, input logic [2:0] c);
        return {r, 2'b00} + {2'b00, r} + {2'b00, c};
    endfunction

endpackage

// File: rtl/matrix_token_acc.sv
// matrix_token_acc: classifies the received byte and accumulates a decimal token.
// The accumulator saturates at its maximum so oversized numbers stay detectably large.
module matrix_token_acc
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             digit_en,
    input  logic [7:0]       rx_data,
    output logic             is_digit,
    output logic             is_sep,
    output logic [ACC_W-1:0] acc,
    output logic             has_digit
);

    logic [ACC_W+3:0] acc_wide;

    assign is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
    assign is_sep   = (rx_data == ASCII_SPACE) || (rx_data == ASCII_LF) || (rx_data == ASCII_CR);

    // For '0'..'9' the low nibble is the digit value.
    assign acc_wide = ({4'b0000, acc} * (ACC_W+4)'(10)) + {{ACC_W{1'b0}}, rx_data[3:0]};

    // Token accumulator: cleared on session start or token close, x10+digit otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            has_digit <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            has_digit <= 1'b0;
        end else if (digit_en) begin
            has_digit <= 1'b1;
            if (acc_wide > {4'b0000, ACC_SAT}) begin
                acc <= ACC_SAT;
            end else begin
                acc <= acc_wide[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/matrix_input_parser.sv
// matrix_input_parser: parses "m n e0 e1 ..." ASCII from the UART receiver and writes
// each element into matrix storage at r*5+c. Started by the controller via start/busy.
// Optional feature: define MATRIX_IN_TIMEOUT_EN for the idle timeout with zero-fill.
//
// rx_valid is a one-cycle strobe with no ready signal: every byte is consumed in the
// cycle it is presented, so the sender never stalls and the parser never drops a byte
// while in a GET_* state.
module matrix_input_parser #(
    parameter int MAX_DIM   = matrix_pkg::MAX_DIM,
    parameter int MAX_VAL   = 9,
    parameter int DATA_W    = 9,
    parameter int TO_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [2:0]        matrix_row,
    output logic [2:0]        matrix_col,
    output logic [2:0]        dbg_state
);
    import matrix_pkg::*;

    localparam logic [ACC_W-1:0] DIM_LIM = ACC_W'(MAX_DIM);
    localparam logic [ACC_W-1:0] VAL_LIM = ACC_W'(MAX_VAL);

    logic [2:0]       state;
    logic [2:0]       r;
    logic [2:0]       c;
    logic [ACC_W-1:0] acc;
    logic             has_digit;
    logic             is_digit;
    logic             is_sep;
    logic             is_bad;
    logic             in_get;
    logic             take;
    logic             accept;
    logic             tok_close;
    logic             to_fire;
    logic             dim_ok;
    logic             last_elem;
    logic [1:0]       fail_code;

    assign dbg_state = state;
    assign in_get    = (state == ST_GET_ROW) || (state == ST_GET_COL) || (state == ST_GET_ELEM);
    assign take      = rx_valid && in_get;
    assign is_bad    = !is_digit && !is_sep;
    assign accept    = (state == ST_IDLE) && start;
    assign dim_ok    = (acc != '0) && (acc <= DIM_LIM);
    assign last_elem = (r == matrix_row - 3'd1) && (c == matrix_col - 3'd1);
    // A timeout in GET_ELEM closes a pending token exactly like a separator would.
    assign tok_close = in_get && has_digit &&
                       ((take && is_sep) || (to_fire && (state == ST_GET_ELEM)));

    matrix_token_acc u_tok (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept || tok_close),
        .digit_en  (take && is_digit),
        .rx_data   (rx_data),
        .is_digit  (is_digit),
        .is_sep    (is_sep),
        .acc       (acc),
        .has_digit (has_digit)
    );

`ifdef MATRIX_IN_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    assign to_fire = in_get && !rx_valid && (to_cnt == TO_W'(TO_CYCLES - 1));

    // Idle counter: restarts on every received byte and whenever no token is being awaited.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!in_get || rx_valid || to_fire) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    // Timeout disabled: a negative length never occurs, so the parser waits indefinitely.
    assign to_fire = (TO_CYCLES < 0);
`endif

    // Error detection for the current cycle; ERR_NONE means the cycle proceeds normally.
    always_comb begin
        fail_code = ERR_NONE;
        if (take && is_bad) begin
            fail_code = ERR_CHAR;
        end else if (to_fire && (state != ST_GET_ELEM)) begin
            fail_code = ERR_DIM;
        end else if (tok_close && (state != ST_GET_ELEM) && !dim_ok) begin
            fail_code = ERR_DIM;
        end else if (tok_close && (state == ST_GET_ELEM) && (acc > VAL_LIM)) begin
            fail_code = ERR_VAL;
        end
    end

    // Session FSM with registered outputs; writes advance c, then r, in row-major order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            matrix_row <= '0;
            matrix_col <= '0;
            r          <= '0;
            c          <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (fail_code != ERR_NONE) begin
                state    <= ST_ERROR;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= fail_code;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            err_code <= ERR_NONE;
                            r        <= '0;
                            c        <= '0;
                            state    <= ST_GET_ROW;
                        end
                    end
                    ST_GET_ROW: begin
                        if (tok_close) begin
                            matrix_row <= acc[2:0];
                            state      <= ST_GET_COL;
                        end
                    end
                    ST_GET_COL: begin
                        if (tok_close) begin
                            matrix_col <= acc[2:0];
                            state      <= ST_GET_ELEM;
                        end
                    end
                    ST_GET_ELEM, ST_FILL: begin
                        if (tok_close || (state == ST_FILL)) begin
                            wr_en   <= 1'b1;
                            wr_addr <= lin_addr(r, c);
                            wr_data <= (state == ST_FILL) ? '0 : DATA_W'(acc);
                            if (last_elem) begin
                                state <= ST_DONE;
                            end else begin
                                if (c == matrix_col - 3'd1) begin
                                    c <= '0;
                                    r <= r + 3'd1;
                                end else begin
                                    c <= c + 3'd1;
                                end
                                if (to_fire) begin
                                    state <= ST_FILL;
                                end
                            end
                        end else if (to_fire) begin
                            state <= ST_FILL;
                        end
                    end
                    ST_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_WAIT_RELEASE;
                    end
                    ST_ERROR: begin
                        state <= ST_WAIT_RELEASE;
                    end
                    ST_WAIT_RELEASE: begin
                        if (!start) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_input_parser.sv
// tb_matrix_input_parser: directed table-driven bench for matrix_input_parser, plus
// hand-written sequences for reset, start-held release, idle bytes and the idle timeout.
module tb_matrix_input_parser;
    import matrix_pkg::*;

    localparam int DATA_W = 9;

    typedef struct {
        string stim;
        string wr;
        int    done_n;
        int    err_v;
        int    code;
        int    row;
        int    col;
        bit    chk_dims;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        matrix_row;
    logic [2:0]        matrix_col;
    logic [2:0]        dbg_state;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [13:0] exp_q[$];
    vec_t vecs[$];

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    matrix_input_parser #(
        .MAX_DIM   (5),
        .MAX_VAL   (9),
        .DATA_W    (DATA_W),
        .TO_CYCLES (50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .matrix_row (matrix_row),
        .matrix_col (matrix_col),
        .dbg_state  (dbg_state)
    );

    // Scoreboard: every storage write is matched against the expected queue in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (wr_en) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: got addr %0d data %0d, required no write", wr_addr, wr_data);
                end else begin
                    logic [13:0] e;
                    e = exp_q.pop_front();
                    if ({wr_addr, wr_data} != e) begin
                        n_fail++;
                        $display("FAIL wr_match: got addr %0d data %0d, required addr %0d data %0d",
                                 wr_addr, wr_data, e[13:9], e[8:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Expected writes given as "addr data addr data ...".
    task automatic push_exp(input string s);
        int  nums[$];
        int  v = 0;
        bit  have = 0;
        for (int i = 0; i < s.len(); i++) begin
            byte ch = s[i];
            if (ch >= 8'h30 && ch <= 8'h39) begin
                v = v * 10 + (ch - 8'h30);
                have = 1;
            end else if (have) begin
                nums.push_back(v);
                v = 0;
                have = 0;
            end
        end
        if (have) nums.push_back(v);
        for (int i = 0; i + 1 < nums.size(); i += 2) begin
            exp_q.push_back({5'(nums[i]), 9'(nums[i+1])});
        end
    endtask

    // Driver: one byte per cycle, called just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_not_busy(input string name, input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_busy_release_bound"}, int'(busy), 0);
    endtask

    task automatic add_vec(input string stim, input string wr, input int done_n, input int err_v,
                           input int code, input int row, input int col, input bit chk_dims);
        vec_t v;
        v.stim = stim; v.wr = wr; v.done_n = done_n; v.err_v = err_v;
        v.code = code; v.row = row; v.col = col; v.chk_dims = chk_dims;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        push_exp(v.wr);
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_on"}, int'(busy), 1);
        check({tag, "_err_clr"}, int'(err), 0);
        send_str(v.stim);
        wait_not_busy(tag, 200);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done_cycles"}, done_cnt, v.done_n);
        check({tag, "_err"}, int'(err), v.err_v);
        check({tag, "_err_code"}, int'(err_code), v.code);
        if (v.chk_dims) begin
            check({tag, "_row"}, int'(matrix_row), v.row);
            check({tag, "_col"}, int'(matrix_col), v.col);
        end
        check({tag, "_writes_missing"}, exp_q.size(), 0);
        check({tag, "_wait_release"}, int'(dbg_state), int'(ST_WAIT_RELEASE));
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_idle"}, int'(dbg_state), int'(ST_IDLE));
        check({tag, "_err_sticky"}, int'(err), v.err_v);
        exp_q.delete();
    endtask

    initial begin
        string s2;
        string w2;

        // Vector table
        add_vec("2 3 1 2 3 4 5 6\n", "0 1 1 2 2 3 5 4 6 5 7 6", 1, 0, 0, 2, 3, 1);
        s2 = "  5\n\n5 ";
        w2 = "";
        for (int i = 0; i < 25; i++) begin
            s2 = {s2, "9 "};
            w2 = {w2, $sformatf("%0d 9 ", i)};
        end
        add_vec(s2, w2, 1, 0, 0, 5, 5, 1);
        add_vec("6 2 ", "", 0, 1, 2, 0, 0, 0);
        add_vec("1 2 7 12 ", "0 7", 0, 1, 3, 1, 2, 1);
        add_vec("3 1 0\r4\r9\r", "0 0 5 4 10 9", 1, 0, 0, 3, 1, 1);
        add_vec("1 1 0009 ", "0 9", 1, 0, 0, 1, 1, 1);
        add_vec("1 1 10 ", "", 0, 1, 3, 1, 1, 1);
        add_vec("0 ", "", 0, 1, 2, 0, 0, 0);
        add_vec("1 5 1 2 3 4 5 ", "0 1 1 2 2 3 3 4 4 5", 1, 0, 0, 1, 5, 1);
        add_vec("1 1 99999999 ", "", 0, 1, 3, 1, 1, 1);
        add_vec("2#", "", 0, 1, 1, 0, 0, 0);
        add_vec("1\t", "", 0, 1, 1, 0, 0, 0);
        add_vec("5 6 ", "", 0, 1, 2, 5, 1, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_row", int'(matrix_row), 0);
        check("rst_col", int'(matrix_col), 0);
        check("rst_state", int'(dbg_state), int'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Bytes while idle are discarded and leave no residue in the next token.
        send_str("7 7 7 ");
        check("idle_discard_state", int'(dbg_state), int'(ST_IDLE));
        check("idle_discard_busy", int'(busy), 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Error with start held: stays in WAIT_RELEASE until start drops, then restarts clean.
        push_exp("0 1");
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        send_str("2 2 1 a");
        repeat (20) @(posedge clk);
        #1;
        check("hold_state", int'(dbg_state), int'(ST_WAIT_RELEASE));
        check("hold_err", int'(err), 1);
        check("hold_code", int'(err_code), 1);
        check("hold_busy", int'(busy), 0);
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        check("restart_busy", int'(busy), 1);
        check("restart_err", int'(err), 0);
        check("restart_code", int'(err_code), 0);
        push_exp("0 3");
        send_str("1 1 3 ");
        wait_not_busy("restart", 50);
        repeat (3) @(posedge clk);
        #1;
        check("restart_done", done_cnt, 1);
        check("restart_writes_missing", exp_q.size(), 0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a session returns everything to reset values.
        push_exp("0 1");
        start = 1'b1;
        @(posedge clk); #1;
        send_str("2 3 1 ");
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst_busy", int'(busy), 0);
        check("midrst_row", int'(matrix_row), 0);
        check("midrst_col", int'(matrix_col), 0);
        check("midrst_state", int'(dbg_state), int'(ST_IDLE));
        check("midrst_writes_missing", exp_q.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Silence after a partial element list.
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
`ifdef MATRIX_IN_TIMEOUT_EN
        push_exp("0 4 1 0 5 0 6 0");
        send_str("2 2 4");
        wait_not_busy("timeout", 200);
        repeat (3) @(posedge clk);
        #1;
        check("timeout_done", done_cnt, 1);
        check("timeout_err", int'(err), 0);
`else
        push_exp("0 4 1 5 5 6 6 7");
        send_str("2 2 4");
        repeat (200) @(posedge clk);
        #1;
        check("silence_busy", int'(busy), 1);
        check("silence_state", int'(dbg_state), int'(ST_GET_ELEM));
        check("silence_no_done", done_cnt, 0);
        send_str(" 5 6 7 ");
        wait_not_busy("silence", 50);
        repeat (3) @(posedge clk);
        #1;
        check("silence_done", done_cnt, 1);
`endif
        check("tail_writes_missing", exp_q.size(), 0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
